data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_pkg.sv | 11 +
 rtl/data_mem_arbiter_if.sv | 38 +++
 rtl/rr_arb2.sv | 19 +
 rtl/data_mem_arbiter.sv | 91 +++++++++
 tb/tb_data_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default bus widths.
package data_mem_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Two-requester data-memory bus: requester handshakes plus the shared memory command port.
interface data_mem_arbiter_if
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              m0_req,    m1_req;
  logic              m0_we,     m1_we;
  logic [ADDR_W-1:0] m0_addr,   m1_addr;
  logic [DATA_W-1:0] m0_wdata,  m1_wdata;
  logic              m0_gnt,    m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata,  m1_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  // Requester / memory side.
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_read, mem_write, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester always wins, ptr breaks ties.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default assignment first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between two requesters with round-robin arbitration.
// One command at a time: IDLE (grant) -> ISSUE (strobe) -> RESP (reads only) -> IDLE.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic               clock,
  input logic               reset_n,
  data_mem_arbiter_if.slave bus
);

  logic [1:0]        state;
  logic              ptr;
  logic              owner;
  logic [1:0]        arb_gnt;
  logic [1:0]        gnt;
  logic              accept;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req ({bus.m1_req, bus.m0_req}),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // Grants exist only in IDLE and never while reset is held.
  assign gnt        = (reset_n && state == ST_IDLE) ? arb_gnt : 2'b00;
  assign bus.m0_gnt = gnt[0];
  assign bus.m1_gnt = gnt[1];
  assign accept     = |gnt;
  assign win        = gnt[1];
  assign bus.busy   = (state != ST_IDLE);

  assign sel_we    = win ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      ptr           <= 1'b0;
      owner         <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_ISSUE;
            ptr           <= ~win;
            owner         <= win;
            bus.mem_read  <= ~sel_we;
            bus.mem_write <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_we ? sel_wdata : '0;
          end
        end
        // The strobe that is high right now tells us whether a response phase follows.
        ST_ISSUE: state <= bus.mem_write ? ST_IDLE : ST_RESP;
        ST_RESP: begin
          state <= ST_IDLE;
          if (owner) begin
            bus.m1_rvalid <= 1'b1;
            bus.m1_rdata  <= bus.mem_rdata;
          end else begin
            bus.m0_rvalid <= 1'b1;
            bus.m0_rdata  <= bus.mem_rdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a transaction-level latency model.
module tb_data_mem_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic rst_req = 1'b0;

  always #5 clock = ~clock;

  data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory behind the arbiter: writes and read data take effect on the falling edge.
  logic [DW-1:0] tb_mem  [8192];
  logic [DW-1:0] ref_mem [8192];

  always @(negedge clock) begin
    if (bus.mem_write === 1'b1) tb_mem[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_read === 1'b1) bus.mem_rdata <= tb_mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester intent: a pending request is held until granted.
  logic          pend    [2];
  logic          p_we    [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];
  int            glog[$];

  // Reference model: command occupancy and read latency expressed as countdowns.
  int            busy_cnt, rv_cnt, rv_owner, pref;
  logic [DW-1:0] rv_data;
  logic          g_valid, g_we;
  int            g_owner;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          exp_rd, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic          exp_rv    [2];
  logic [DW-1:0] exp_rdata [2];

  task automatic advance_model(input logic rst_at_edge);
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (!rst_at_edge) begin
      busy_cnt = 0; rv_cnt = 0; pref = 0; g_valid = 1'b0;
      exp_addr = '0; exp_wdata = '0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
    end else begin
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          exp_rv[rv_owner]    = 1'b1;
          exp_rdata[rv_owner] = rv_data;
        end
      end
      if (busy_cnt > 0) busy_cnt--;
      if (g_valid) begin
        g_valid   = 1'b0;
        exp_wr    = g_we;
        exp_rd    = !g_we;
        exp_addr  = g_addr;
        exp_wdata = g_we ? g_wdata : '0;
        busy_cnt  = g_we ? 1 : 2;
        if (g_we) ref_mem[g_addr] = g_wdata;
        else begin
          rv_cnt   = 2;
          rv_owner = g_owner;
          rv_data  = ref_mem[g_addr];
        end
      end
    end
  endtask

  task automatic tick();
    int win;
    @(posedge clock);
    #1;
    advance_model(reset_n);
    check("mem_read",  bus.mem_read,  exp_rd);
    check("mem_write", bus.mem_write, exp_wr);
    check("mem_addr",  bus.mem_addr,  exp_addr);
    check("mem_wdata", bus.mem_wdata, exp_wdata);
    check("busy",      bus.busy,      busy_cnt > 0);
    check("m0_rvalid", bus.m0_rvalid, exp_rv[0]);
    check("m1_rvalid", bus.m1_rvalid, exp_rv[1]);
    check("m0_rdata",  bus.m0_rdata,  exp_rdata[0]);
    check("m1_rdata",  bus.m1_rdata,  exp_rdata[1]);

    reset_n      = rst_req;
    bus.m0_req   = pend[0];
    bus.m0_we    = p_we[0];
    bus.m0_addr  = p_addr[0];
    bus.m0_wdata = p_wdata[0];
    bus.m1_req   = pend[1];
    bus.m1_we    = p_we[1];
    bus.m1_addr  = p_addr[1];
    bus.m1_wdata = p_wdata[1];
    #1;

    win = -1;
    if (reset_n && busy_cnt == 0) begin
      if (pend[0] && pend[1]) win = pref;
      else if (pend[0])       win = 0;
      else if (pend[1])       win = 1;
    end
    check("m0_gnt", bus.m0_gnt, win == 0);
    check("m1_gnt", bus.m1_gnt, win == 1);
    if (win >= 0) begin
      g_valid   = 1'b1;
      g_owner   = win;
      g_we      = p_we[win];
      g_addr    = p_addr[win];
      g_wdata   = p_wdata[win];
      pref      = 1 - win;
      pend[win] = 1'b0;
      glog.push_back(win);
    end
  endtask

  task automatic post(input int m, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data);
    pend[m]    = 1'b1;
    p_we[m]    = we;
    p_addr[m]  = addr;
    p_wdata[m] = data;
  endtask

  task automatic run_req(input int m, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    post(m, we, addr, data);
    for (int i = 0; i < 40 && pend[m]; i++) tick();
    check("grant_timeout", pend[m], 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < 40 && (pend[0] || pend[1]); i++) tick();
    check("drain_timeout", pend[0] || pend[1], 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 13'h1FFF;
      default: return AW'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic spawn(input int m, input int pct);
    if (!pend[m] && $urandom_range(0, 99) < pct)
      post(m, 1'($urandom_range(0, 1)), pick_addr(), $urandom);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; p_we[m] = 1'b0; p_addr[m] = '0; p_wdata[m] = '0;
    end
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.mem_rdata = '0;
    g_valid = 1'b0;

    // Reset values, with a request already waiting that must not be granted.
    rst_req = 1'b0;
    post(1, 1'b0, 13'd3, '0);
    tick(); tick(); tick();
    pend[1] = 1'b0;
    rst_req = 1'b1;
    tick();

    // Simultaneous requests right after reset: m0 first, then m1, then alternating.
    glog.delete();
    post(0, 1'b1, 13'd100, 32'hA0);
    post(1, 1'b1, 13'd101, 32'hA1);
    drain(0);
    post(0, 1'b0, 13'd100, '0);
    post(1, 1'b0, 13'd101, '0);
    drain(3);
    check("rr_n_grants", glog.size(), 4);
    if (glog.size() == 4) begin
      check("rr_grant0", glog[0], 0);
      check("rr_grant1", glog[1], 1);
      check("rr_grant2", glog[2], 0);
      check("rr_grant3", glog[3], 1);
    end
    check("rr_m1_rdata", bus.m1_rdata, 32'hA1);

    // Write then read back through m0.
    run_req(0, 1'b1, 13'd5, 32'h1234);
    drain(2);
    run_req(0, 1'b0, 13'd5, '0);
    drain(4);
    check("m0_read_back", bus.m0_rdata, 32'h1234);

    // Top address holding -1, read by m1 only.
    run_req(1, 1'b1, 13'h1FFF, 32'hFFFF_FFFF);
    drain(2);
    run_req(1, 1'b0, 13'h1FFF, '0);
    drain(4);
    check("m1_read_top", bus.m1_rdata, 32'hFFFF_FFFF);
    check("m0_rdata_kept", bus.m0_rdata, 32'h1234);

    // Reset during RESP of an m0 read: no rvalid, idle, pointer back to m0.
    run_req(0, 1'b0, 13'd5, '0);
    tick();
    rst_req = 1'b0;
    tick();
    rst_req = 1'b1;
    post(0, 1'b1, 13'd7, 32'h77);
    post(1, 1'b1, 13'd8, 32'h88);
    tick();
    check("rst_no_rvalid", bus.m0_rvalid, 1'b0);
    check("rst_rdata_clr", bus.m0_rdata, '0);
    check("rst_next_m0", bus.m0_gnt, 1'b1);
    drain(3);

    // m0 hammers while busy, m1 occasionally competes.
    for (int i = 0; i < 200; i++) begin
      spawn(0, 100);
      spawn(1, 30);
      tick();
    end
    drain(3);

    // Free-running random traffic.
    for (int i = 0; i < 1500; i++) begin
      spawn(0, 50);
      spawn(1, 50);
      tick();
    end
    drain(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
